config_fabric: RTL
==================

// Module: config_fabric
// PURPOSE
//  Parametrised config-bus fabric between the HPS Avalon-MM config slave and NUM_CLIENTS accelerator
//  config ports. Replaces wired-OR readdata/readdatavalid sharing with address-decoded, registered
//  routing. Allows one outstanding transaction. Aggregates per-client IRQs into hps_irq via mask/pending regs.
// PARAMETERS
//  NUM_CLIENTS  4      number of client config ports (1..15)
//  ADDR_W       16     config word-address width
//  DATA_W       32     config data width
//  SEL_LSB      12     client index = address[SEL_LSB +: 4]; index >= NUM_CLIENTS selects local regs
//  TIMEOUT      255    read-response timeout in cycles (only with CFG_FABRIC_TIMEOUT_EN)
// PORTS
//  clk                       in   1                clock
//  reset                     in   1                asynchronous, active-low reset
//  avs_config_address        in   ADDR_W           host word address
//  avs_config_write          in   1                host write request
//  avs_config_writedata      in   DATA_W           host write data
//  avs_config_read           in   1                host read request
//  avs_config_readdata       out  DATA_W           read response data
//  avs_config_readdatavalid  out  1                read response strobe, 1 cycle
//  avs_config_waitrequest    out  1                host must hold its request while this is high
//  cli_address               out  ADDR_W           shared address to clients, registered
//  cli_writedata             out  DATA_W           shared write data, registered
//  cli_write                 out  NUM_CLIENTS      one-hot write strobe
//  cli_read                  out  NUM_CLIENTS      one-hot read strobe
//  cli_waitrequest           in   NUM_CLIENTS      per-client waitrequest
//  cli_readdata              in   NUM_CLIENTS*DATA_W  packed per-client read data
//  cli_readdatavalid         in   NUM_CLIENTS      per-client response strobe
//  cli_irq                   in   NUM_CLIENTS      level interrupt per client
//  hps_irq                   out  1                registered OR of (pend & mask)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, IRQ_MASK=0, IRQ_PEND=0, ERR=0.
//  FSM IDLE/CMD/RWAIT/RESP. avs_config_waitrequest=0 only in IDLE.
//  - Accept in IDLE on (read|write). If read and write are both high, the write wins and ERR.illegal is set.
//  - Client target: latch addr/data and cli_index. Next cycle drive one-hot cli_write/cli_read in CMD.
//    Hold the strobe until the selected cli_waitrequest is sampled 0.
//  - Write: CMD -> IDLE when the write is taken.
//  - Read: CMD -> RWAIT when the read is taken. On the selected cli_readdatavalid, register readdata
//    -> RESP, which pulses avs_config_readdatavalid for 1 cycle -> IDLE.
//    Accept-to-valid latency = 3 + client wait + client read latency.
//  - Local target: write takes effect in the accept cycle. A read goes directly to RESP
//    (readdatavalid 2 cycles after accept).
//  - cli_readdatavalid from any non-selected client, or in any state other than RWAIT, is dropped
//    and sets ERR.spurious (sticky).
//  Local regs (address[1:0]):
//    0 ID {NUM_CLIENTS[7:0], 24'hCF0B01} RO
//    1 IRQ_MASK RW
//    2 IRQ_PEND W1C
//    3 ERR {illegal, spurious, timeout, last_client[3:0]} W1C on bits 6:4
//  IRQ_PEND |= cli_irq every cycle. Set beats a W1C clear in the same cycle.
//  hps_irq lags by 1 cycle.
// CONFIGURATION
//  CFG_FABRIC_TIMEOUT_EN defined:
//    - An 8-bit counter runs in RWAIT. At TIMEOUT cycles: respond with 32'hDEAD_0000 | cli_index,
//      set ERR.timeout, release cli_read, go to RESP.
//    - A late response from that client then counts as spurious.
//  Undefined: RWAIT waits indefinitely. ERR.timeout reads 0.
// STRUCTURE
//  config_fabric_pkg:
//    - state enum
//    - local register offsets
//    - ID constant
//    - timeout error word
//    - ERR bit positions
//  Sub-module config_fabric_irq: IRQ_MASK/IRQ_PEND storage, W1C logic, hps_irq register.
// TESTING
//  1 Reset low mid-RWAIT -> all outputs 0 next edge; ID read afterwards returns {8'd4,24'hCF0B01}.
//  2 Write 0x1234 to addr 0x2004, client2 waitrequest high 3 cycles
//    -> cli_write=4'b0100 held 4 cycles, cli_address=0x2004, host waitrequest high until IDLE.
//  3 Read 0x1008, client1 returns 0xA5A5 after 5 cycles; client3 pulses readdatavalid meanwhile
//    -> host gets 0xA5A5 once, ERR.spurious=1.
//  4 cli_irq[3] pulse with mask=0 -> hps_irq 0, PEND[3]=1. Set mask=8 -> hps_irq 1.
//    W1C 8 while irq is still high -> PEND stays 1.
//  5 (TIMEOUT_EN) read client0, no response -> readdatavalid after 255 RWAIT cycles,
//    data 0xDEAD0000, ERR.timeout=1.
//  6 Read and write asserted together to local IRQ_MASK -> write applied, ERR.illegal=1, no readdatavalid.

Source files
------------

// File: rtl/config_fabric_pkg.sv
// config_fabric_pkg: shared FSM states, local register map and constants for the config fabric.
package config_fabric_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RWAIT, S_RESP} state_t;
  localparam logic [1:0] REG_ID = 2'd0, REG_MASK = 2'd1, REG_PEND = 2'd2, REG_ERR = 2'd3;
  localparam logic [23:0] ID_LO = 24'hCF0B01;
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_0000;
  localparam int ERR_ILLEGAL = 6, ERR_SPURIOUS = 5, ERR_TIMEOUT = 4;
  function automatic logic [31:0] id_word(input logic [7:0] n);
    return {n, ID_LO};
  endfunction
endpackage

// File: rtl/config_fabric_irq.sv
// config_fabric_irq: IRQ mask/pending storage with W1C clear and registered host interrupt.
module config_fabric_irq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_irq,
  input  logic         i_mask_we,
  input  logic         i_pend_w1c,
  input  logic [N-1:0] i_wdata,
  output logic [N-1:0] o_mask,
  output logic [N-1:0] o_pend,
  output logic         o_hps_irq
);
  logic [N-1:0] r_mask, r_pend;
  logic         r_hps;
  logic [N-1:0] w_clr;
  assign w_clr = i_pend_w1c ? i_wdata : '0;
  // new interrupt levels are ORed in after the clear so a concurrent set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
      r_pend <= '0;
      r_hps  <= 1'b0;
    end else begin
      r_mask <= i_mask_we ? i_wdata : r_mask;
      r_pend <= (r_pend & ~w_clr) | i_irq;
      r_hps  <= |(r_pend & r_mask);
    end
  end
  assign o_mask    = r_mask;
  assign o_pend    = r_pend;
  assign o_hps_irq = r_hps;
endmodule

// File: rtl/config_fabric.sv
// config_fabric: address-decoded, registered Avalon-MM config fabric, one outstanding transaction.
// Read-response timeout is built only when CFG_FABRIC_TIMEOUT_EN is defined.
module config_fabric
  import config_fabric_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             avs_config_address,
  input  logic                          avs_config_write,
  input  logic [DATA_W-1:0]             avs_config_writedata,
  input  logic                          avs_config_read,
  output logic [DATA_W-1:0]             avs_config_readdata,
  output logic                          avs_config_readdatavalid,
  output logic                          avs_config_waitrequest,
  output logic [ADDR_W-1:0]             cli_address,
  output logic [DATA_W-1:0]             cli_writedata,
  output logic [NUM_CLIENTS-1:0]        cli_write,
  output logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS-1:0]        cli_waitrequest,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_readdata,
  input  logic [NUM_CLIENTS-1:0]        cli_readdatavalid,
  input  logic [NUM_CLIENTS-1:0]        cli_irq,
  output logic                          hps_irq
);
`ifdef CFG_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [4:0] NC = 5'(NUM_CLIENTS);
  state_t                 r_state, w_next;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata, r_rdata, w_lrd, w_crd;
  logic [3:0]             r_idx, r_last, w_sel;
  logic [7:0]             r_cnt;
  logic                   r_wr, r_rvalid, r_ill, r_spur, r_tout;
  logic [NUM_CLIENTS-1:0] w_mask, w_pend, w_oh, w_exp;
  logic [1:0]             w_reg;
  logic                   w_acc, w_local, w_lwr, w_lrd_acc, w_cwait, w_hit, w_to, w_spur, w_errc;
  assign w_sel     = avs_config_address[SEL_LSB +: 4];
  assign w_reg     = avs_config_address[1:0];
  assign w_local   = {1'b0, w_sel} >= NC;
  assign w_acc     = (r_state == S_IDLE) && (avs_config_read || avs_config_write);
  assign w_lwr     = w_acc && avs_config_write && w_local;
  assign w_lrd_acc = w_acc && avs_config_read && !avs_config_write && w_local;
  assign w_errc    = w_lwr && (w_reg == REG_ERR);
  assign w_oh      = NUM_CLIENTS'(1) << r_idx;
  assign w_cwait   = |(cli_waitrequest & w_oh);
  assign w_exp     = (r_state == S_RWAIT) ? w_oh : '0;
  assign w_hit     = |(cli_readdatavalid & w_exp);
  assign w_spur    = |(cli_readdatavalid & ~w_exp);
  assign w_to      = TO_EN && (r_state == S_RWAIT) && !w_hit && (r_cnt == 8'(TIMEOUT - 1));
  assign w_crd     = cli_readdata[r_idx*DATA_W +: DATA_W];
  assign w_lrd     = (w_reg == REG_ID)   ? DATA_W'(id_word(8'(NUM_CLIENTS))) :
                     (w_reg == REG_MASK) ? DATA_W'(w_mask) :
                     (w_reg == REG_PEND) ? DATA_W'(w_pend) :
                                           DATA_W'({r_ill, r_spur, r_tout, r_last});
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_next = w_local ? (w_lrd_acc ? S_RESP : S_IDLE) : S_CMD;
      S_CMD:   if (!w_cwait) w_next = r_wr ? S_IDLE : S_RWAIT;
      S_RWAIT: if (w_hit || w_to) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  // readdatavalid is registered off RESP, giving a local read its two-cycle latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_wr     <= 1'b0;
      r_rvalid <= 1'b0;
      r_ill    <= 1'b0;
      r_spur   <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= r_state == S_RESP;
      r_cnt    <= (r_state == S_RWAIT) ? r_cnt + 8'd1 : 8'd0;
      if (w_acc) begin
        r_addr  <= avs_config_address;
        r_wdata <= avs_config_writedata;
        r_idx   <= w_sel;
        r_wr    <= avs_config_write;
      end
      if (w_acc && !w_local) r_last <= w_sel;
      if (w_lrd_acc) r_rdata <= w_lrd;
      else if (w_hit) r_rdata <= w_crd;
      else if (w_to) r_rdata <= DATA_W'(TIMEOUT_WORD | 32'(r_idx));
      r_ill  <= (w_acc && avs_config_read && avs_config_write) ||
                (r_ill && !(w_errc && avs_config_writedata[ERR_ILLEGAL]));
      r_spur <= w_spur || (r_spur && !(w_errc && avs_config_writedata[ERR_SPURIOUS]));
      r_tout <= w_to || (r_tout && !(w_errc && avs_config_writedata[ERR_TIMEOUT]));
    end
  end
  config_fabric_irq #(.N(NUM_CLIENTS)) u_irq (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (cli_irq),
    .i_mask_we (w_lwr && (w_reg == REG_MASK)),
    .i_pend_w1c(w_lwr && (w_reg == REG_PEND)),
    .i_wdata   (avs_config_writedata[NUM_CLIENTS-1:0]),
    .o_mask    (w_mask),
    .o_pend    (w_pend),
    .o_hps_irq (hps_irq)
  );
  assign avs_config_readdata      = r_rdata;
  assign avs_config_readdatavalid = r_rvalid;
  assign avs_config_waitrequest   = r_state != S_IDLE;
  assign cli_address              = r_addr;
  assign cli_writedata            = r_wdata;
  assign cli_write                = (r_state == S_CMD && r_wr) ? w_oh : '0;
  assign cli_read                 = (r_state == S_CMD && !r_wr) ? w_oh : '0;
endmodule
